// File: rtl/ifetch_line_buffer_if.sv
// Fetch-side read port plus memory line-request/response channel of the
// instruction line buffer. The buffer is the slave; the fetch/memory side is the master.
interface ifetch_line_buffer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] S_R_ADDR;
  logic                  S_R_ADDR_VALID;
  logic [31:0]           S_R_DATA;
  logic                  S_R_DATA_VALID;
  logic                  invalidate;
  logic                  M_REQ_VALID;
  logic                  M_REQ_READY;
  logic [ADDR_WIDTH-1:0] M_REQ_ADDR;
  logic                  M_RESP_VALID;
  logic [DATA_WIDTH-1:0] M_RESP_DATA;

  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, invalidate, M_REQ_READY, M_RESP_VALID, M_RESP_DATA,
    input  S_R_DATA, S_R_DATA_VALID, M_REQ_VALID, M_REQ_ADDR
  );

  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, invalidate, M_REQ_READY, M_RESP_VALID, M_RESP_DATA,
    output S_R_DATA, S_R_DATA_VALID, M_REQ_VALID, M_REQ_ADDR
  );
endinterface

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction buffer: zero-latency hits from one cached line,
// misses refill the whole line as a burst of DATA_WIDTH-bit beats.
module ifetch_line_buffer #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  ifetch_line_buffer_if.slave  bus,
  output logic [31:0]          miss_count
);
  localparam int BEATS = BUFFER_SIZE / DATA_WIDTH;
  localparam int OFF   = $clog2(BUFFER_SIZE / 8);
  localparam int TAG_W = ADDR_WIDTH - OFF;
  localparam int BCW   = $clog2(BEATS);
  localparam int WORDS = BUFFER_SIZE / 32;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                 state;
  logic [BUFFER_SIZE-1:0] line_data;
  logic [TAG_W-1:0]       line_tag;
  logic [TAG_W-1:0]       req_tag;
  logic [TAG_W-1:0]       addr_tag;
  logic                   line_valid;
  logic                   drop_fill;
  logic [BCW-1:0]         beat_cnt;
  logic                   hit;
  logic [31:0]            rd_word;
  logic                   unused_addr_bits;

  assign addr_tag         = bus.S_R_ADDR[ADDR_WIDTH-1:OFF];
  assign unused_addr_bits = ^bus.S_R_ADDR[1:0];

  assign hit = (state == IDLE) && line_valid && bus.S_R_ADDR_VALID &&
               (addr_tag == line_tag) && !bus.invalidate;

  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < WORDS; w++)
      if (bus.S_R_ADDR[OFF-1:2] == (OFF-2)'(w))
        rd_word = line_data[w*32 +: 32];
  end

  assign bus.S_R_DATA_VALID = hit;
  assign bus.S_R_DATA       = hit ? rd_word : '0;

  // Line storage is deliberately not reset; line_valid guards it.
  always_ff @(posedge clk) begin
    if (!reset && state == FILL && bus.M_RESP_VALID)
      for (int unsigned b = 0; b < BEATS; b++)
        if (beat_cnt == BCW'(b))
          line_data[b*DATA_WIDTH +: DATA_WIDTH] <= bus.M_RESP_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      line_valid      <= 1'b0;
      line_tag        <= '0;
      req_tag         <= '0;
      beat_cnt        <= '0;
      drop_fill       <= 1'b0;
      miss_count      <= '0;
      bus.M_REQ_VALID <= 1'b0;
      bus.M_REQ_ADDR  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.invalidate) begin
            line_valid <= 1'b0;
          end else if (bus.S_R_ADDR_VALID && !hit) begin
            req_tag         <= addr_tag;
            beat_cnt        <= '0;
            bus.M_REQ_VALID <= 1'b1;
            bus.M_REQ_ADDR  <= {addr_tag, {OFF{1'b0}}};
            if (miss_count != '1)
              miss_count <= miss_count + 32'd1;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.invalidate) begin
            drop_fill  <= 1'b1;
            line_valid <= 1'b0;
          end
          if (bus.M_REQ_READY) begin
            bus.M_REQ_VALID <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (bus.invalidate) begin
            drop_fill  <= 1'b1;
            line_valid <= 1'b0;
          end
          if (bus.M_RESP_VALID) begin
            beat_cnt <= beat_cnt + 1'b1;
            // An invalidate coinciding with the last beat still drops the line.
            if (beat_cnt == BCW'(BEATS-1)) begin
              line_tag   <= req_tag;
              line_valid <= !drop_fill && !bus.invalidate;
              drop_fill  <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
